// File: rtl/openddr_addr_mapper_if.sv
// Request/response bundle between the AXI front end, the address mapper and the scheduler.
interface openddr_addr_mapper_if #(
   parameter int unsigned ADDR_WIDTH = 40,
   parameter int unsigned RANK_WIDTH = 1,
   parameter int unsigned BG_WIDTH   = 2,
   parameter int unsigned BANK_WIDTH = 2,
   parameter int unsigned ROW_WIDTH  = 16,
   parameter int unsigned COL_WIDTH  = 10,
   parameter int unsigned ID_WIDTH   = 8
);
   logic                  in_valid;
   logic                  in_ready;
   logic [ADDR_WIDTH-1:0] in_addr;
   logic [ID_WIDTH-1:0]   in_id;
   logic                  out_valid;
   logic                  out_ready;
   logic [RANK_WIDTH-1:0] out_rank;
   logic [BG_WIDTH-1:0]   out_bg;
   logic [BANK_WIDTH-1:0] out_bank;
   logic [ROW_WIDTH-1:0]  out_row;
   logic [COL_WIDTH-1:0]  out_col;
   logic [ID_WIDTH-1:0]   out_id;
   logic                  out_err;

   modport slave (
      input  in_valid, in_addr, in_id, out_ready,
      output in_ready, out_valid, out_rank, out_bg, out_bank, out_row, out_col, out_id, out_err
   );

   modport master (
      output in_valid, in_addr, in_id, out_ready,
      input  in_ready, out_valid, out_rank, out_bg, out_bank, out_row, out_col, out_id, out_err
   );
endinterface

// File: rtl/openddr_addr_mapper.sv
// Two-stage elastic AXI address -> rank/bg/bank/row/col mapper with optional bank hash.
// Optional statistics counters are built when OPENDDR_ADDR_STATS_EN is defined.
module openddr_addr_mapper #(
   parameter int unsigned ADDR_WIDTH     = 40,
   parameter int unsigned RANK_WIDTH     = 1,
   parameter int unsigned BG_WIDTH       = 2,
   parameter int unsigned BANK_WIDTH     = 2,
   parameter int unsigned ROW_WIDTH      = 16,
   parameter int unsigned COL_WIDTH      = 10,
   parameter int unsigned BYTE_OFFSET    = 3,
   parameter int unsigned BURST_COL_BITS = 3,
   parameter int unsigned ID_WIDTH       = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  cfg_mode,
   input  logic        cfg_xor_en,
`ifdef OPENDDR_ADDR_STATS_EN
   input  logic        stat_clr,
   output logic [31:0] stat_req_cnt,
   output logic [15:0] stat_err_cnt,
`endif
   openddr_addr_mapper_if.slave bus
);
   localparam int unsigned MapW    = COL_WIDTH + BG_WIDTH + BANK_WIDTH + ROW_WIDTH + RANK_WIDTH;
   localparam int unsigned UsedW   = BYTE_OFFSET + MapW;
   localparam int unsigned RowLsb  = COL_WIDTH + BG_WIDTH + BANK_WIDTH;
   localparam int unsigned RankLsb = RowLsb + ROW_WIDTH;
   localparam int unsigned ColHiW  = COL_WIDTH - BURST_COL_BITS;

   if (UsedW > ADDR_WIDTH) begin : g_chk_width
      $fatal(1, "openddr_addr_mapper: mapped fields exceed ADDR_WIDTH");
   end
   if (BURST_COL_BITS >= COL_WIDTH) begin : g_chk_burst
      $fatal(1, "openddr_addr_mapper: BURST_COL_BITS must be below COL_WIDTH");
   end

   logic [MapW-1:0] a;
   logic            hi_nz;
   assign a = bus.in_addr[UsedW-1:BYTE_OFFSET];

   if (ADDR_WIDTH > UsedW) begin : g_hi
      assign hi_nz = |bus.in_addr[ADDR_WIDTH-1:UsedW];
   end else begin : g_no_hi
      assign hi_nz = 1'b0;
   end

   // Byte-lane bits never reach the DRAM command.
   if (BYTE_OFFSET > 0) begin : g_low
      logic unused_low;
      assign unused_low = ^bus.in_addr[BYTE_OFFSET-1:0];
   end

   logic [COL_WIDTH-1:0]  raw_col;
   logic [BANK_WIDTH-1:0] raw_bank;
   logic [BG_WIDTH-1:0]   raw_bg;

   always_comb begin
      raw_col  = a[COL_WIDTH-1:0];
      raw_bank = a[COL_WIDTH +: BANK_WIDTH];
      raw_bg   = a[COL_WIDTH+BANK_WIDTH +: BG_WIDTH];
      case (cfg_mode)
         2'd1: begin
            raw_bank = a[0 +: BANK_WIDTH];
            raw_bg   = a[BANK_WIDTH +: BG_WIDTH];
            raw_col  = a[BANK_WIDTH+BG_WIDTH +: COL_WIDTH];
         end
         2'd2: begin
            raw_col  = {a[BURST_COL_BITS+BG_WIDTH +: ColHiW], a[0 +: BURST_COL_BITS]};
            raw_bg   = a[BURST_COL_BITS +: BG_WIDTH];
            raw_bank = a[COL_WIDTH+BG_WIDTH +: BANK_WIDTH];
         end
         default: ;
      endcase
   end

   logic                  s1_valid_q, s2_valid_q;
   logic [COL_WIDTH-1:0]  s1_col_q, s2_col_q;
   logic [BANK_WIDTH-1:0] s1_bank_q, s2_bank_q;
   logic [BG_WIDTH-1:0]   s1_bg_q, s2_bg_q;
   logic [ROW_WIDTH-1:0]  s1_row_q, s2_row_q;
   logic [RANK_WIDTH-1:0] s1_rank_q, s2_rank_q;
   logic [ID_WIDTH-1:0]   s1_id_q, s2_id_q;
   logic                  s1_xor_q, s1_rsvd_q, s1_hi_q, s2_err_q;
   logic                  s2_ready, in_ready, s1_load, s2_load;

   assign s2_ready = !s2_valid_q || bus.out_ready;
   assign in_ready = !s1_valid_q || s2_ready;
   assign s1_load  = bus.in_valid && in_ready;
   assign s2_load  = s1_valid_q && s2_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_col_q   <= '0;
         s1_bank_q  <= '0;
         s1_bg_q    <= '0;
         s1_row_q   <= '0;
         s1_rank_q  <= '0;
         s1_id_q    <= '0;
         s1_xor_q   <= 1'b0;
         s1_rsvd_q  <= 1'b0;
         s1_hi_q    <= 1'b0;
      end else begin
         if (in_ready) s1_valid_q <= bus.in_valid;
         if (s1_load) begin
            s1_col_q  <= raw_col;
            s1_bank_q <= raw_bank;
            s1_bg_q   <= raw_bg;
            s1_row_q  <= a[RowLsb +: ROW_WIDTH];
            s1_rank_q <= a[RankLsb +: RANK_WIDTH];
            s1_id_q   <= bus.in_id;
            s1_xor_q  <= cfg_xor_en;
            s1_rsvd_q <= (cfg_mode == 2'd3);
            s1_hi_q   <= hi_nz;
         end
      end
   end

   logic [BANK_WIDTH-1:0] hash_bank;
   logic [BG_WIDTH-1:0]   hash_bg;
   assign hash_bank = s1_xor_q ? (s1_bank_q ^ s1_row_q[BANK_WIDTH-1:0]) : s1_bank_q;
   assign hash_bg   = s1_xor_q ? (s1_bg_q ^ s1_row_q[BANK_WIDTH +: BG_WIDTH]) : s1_bg_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid_q <= 1'b0;
         s2_col_q   <= '0;
         s2_bank_q  <= '0;
         s2_bg_q    <= '0;
         s2_row_q   <= '0;
         s2_rank_q  <= '0;
         s2_id_q    <= '0;
         s2_err_q   <= 1'b0;
      end else begin
         if (s2_ready) s2_valid_q <= s1_valid_q;
         if (s2_load) begin
            s2_col_q  <= s1_col_q;
            s2_bank_q <= hash_bank;
            s2_bg_q   <= hash_bg;
            s2_row_q  <= s1_row_q;
            s2_rank_q <= s1_rank_q;
            s2_id_q   <= s1_id_q;
            s2_err_q  <= s1_rsvd_q || s1_hi_q;
         end
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = s2_valid_q;
   assign bus.out_col   = s2_col_q;
   assign bus.out_bank  = s2_bank_q;
   assign bus.out_bg    = s2_bg_q;
   assign bus.out_row   = s2_row_q;
   assign bus.out_rank  = s2_rank_q;
   assign bus.out_id    = s2_id_q;
   assign bus.out_err   = s2_err_q;

`ifdef OPENDDR_ADDR_STATS_EN
   // Clear wins over a same-cycle handshake; the error count saturates, the request count wraps.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_req_cnt <= '0;
         stat_err_cnt <= '0;
      end else if (stat_clr) begin
         stat_req_cnt <= '0;
         stat_err_cnt <= '0;
      end else if (s2_valid_q && bus.out_ready) begin
         stat_req_cnt <= stat_req_cnt + 32'd1;
         if (s2_err_q && (stat_err_cnt != 16'hFFFF)) stat_err_cnt <= stat_err_cnt + 16'd1;
      end
   end
`else
   // Statistics disabled: no counters are built.
`endif
endmodule

// File: tb/tb_openddr_addr_mapper.sv
// Self-checking bench for openddr_addr_mapper: directed plan cases plus a randomized
// stream checked against an arithmetic reference model and scoreboard.
module tb_openddr_addr_mapper;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] cfg_mode;
   logic       cfg_xor_en;
`ifdef OPENDDR_ADDR_STATS_EN
   logic        stat_clr;
   logic [31:0] stat_req_cnt;
   logic [15:0] stat_err_cnt;
`endif

   always #5 clk = ~clk;

   openddr_addr_mapper_if bus ();

   openddr_addr_mapper dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cfg_mode   (cfg_mode),
      .cfg_xor_en (cfg_xor_en),
`ifdef OPENDDR_ADDR_STATS_EN
      .stat_clr     (stat_clr),
      .stat_req_cnt (stat_req_cnt),
      .stat_err_cnt (stat_err_cnt),
`endif
      .bus        (bus)
   );

   int tests = 0;
   int fails = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: fields computed arithmetically from the layout rules (default parameters).
   function automatic logic [39:0] model(input logic [39:0] addr, input logic [1:0] mode,
                                         input logic x, input logic [7:0] id);
      longint unsigned w, col, bank, bg, row, rank;
      logic err;
      w    = 64'(addr) / 8;
      row  = (w / (64'd1 << 14)) % 65536;
      rank = (w / (64'd1 << 30)) % 2;
      case (mode)
         2'd1: begin
            bank = w % 4;
            bg   = (w / 4) % 4;
            col  = (w / 16) % 1024;
         end
         2'd2: begin
            col  = (w % 8) + ((w / 32) % 128) * 8;
            bg   = (w / 8) % 4;
            bank = (w / 4096) % 4;
         end
         default: begin
            col  = w % 1024;
            bank = (w / 1024) % 4;
            bg   = (w / 4096) % 4;
         end
      endcase
      if (x) begin
         bank = bank ^ (row % 4);
         bg   = bg ^ ((row / 4) % 4);
      end
      err = ((64'(addr) >> 34) != 0) || (mode == 2'd3);
      return {rank[0], bg[1:0], bank[1:0], row[15:0], col[9:0], id, err};
   endfunction

   function automatic logic [39:0] obs_vec();
      return {bus.out_rank, bus.out_bg, bus.out_bank, bus.out_row, bus.out_col, bus.out_id,
              bus.out_err};
   endfunction

   function automatic logic [39:0] rand_addr();
      logic [39:0] r;
      r = 40'({$urandom, $urandom});
      if ($urandom_range(0, 3) != 0) r[39:34] = 6'd0;
      return r;
   endfunction

   // Issue one request into an empty pipe, check 2-cycle latency; leaves the result held.
   task automatic single(input string tag, input logic [39:0] addr, input logic [1:0] mode,
                         input logic x, input logic [7:0] id);
      @(negedge clk);
      bus.in_addr = addr;
      bus.in_id = id;
      cfg_mode = mode;
      cfg_xor_en = x;
      bus.in_valid = 1'b1;
      bus.out_ready = 1'b0;
      @(negedge clk);
      bus.in_valid = 1'b0;
      cfg_mode = 2'd3;
      cfg_xor_en = ~x;
      check({tag, "_lat1"}, 64'(bus.out_valid), 64'd0);
      @(negedge clk);
      check({tag, "_lat2"}, 64'(bus.out_valid), 64'd1);
      check({tag, "_model"}, 64'(obs_vec()), 64'(model(addr, mode, x, id)));
   endtask

   task automatic drain_one();
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
   endtask

   logic [39:0] q[$];
   logic [39:0] exp_v;
   int          hs, errs, exp_out;
   logic        pend, acc;

   initial begin
      bus.in_valid = 1'b0;
      bus.in_addr = '0;
      bus.in_id = '0;
      bus.out_ready = 1'b0;
      cfg_mode = 2'd0;
      cfg_xor_en = 1'b0;
`ifdef OPENDDR_ADDR_STATS_EN
      stat_clr = 1'b0;
`endif
      #12;
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_in_ready", 64'(bus.in_ready), 64'd1);
      check("rst_fields", 64'(obs_vec()), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      single("m0", 40'hB2038, 2'd0, 1'b0, 8'h11);
      check("m0_row", 64'(bus.out_row), 64'd5);
      check("m0_bg", 64'(bus.out_bg), 64'd2);
      check("m0_bank", 64'(bus.out_bank), 64'd1);
      check("m0_col", 64'(bus.out_col), 64'd7);
      check("m0_rank_err", 64'({bus.out_rank, bus.out_err}), 64'd0);
      check("m0_id", 64'(bus.out_id), 64'h11);
      drain_one();
      check("m0_drained", 64'(bus.out_valid), 64'd0);

      single("xor", 40'hB2038, 2'd0, 1'b1, 8'h12);
      check("xor_bank_bg", 64'({bus.out_bank, bus.out_bg}), 64'({2'd0, 2'd3}));
      check("xor_row_col", 64'({bus.out_row, bus.out_col}), 64'({16'd5, 10'd7}));
      drain_one();

      single("m1", 40'h28, 2'd1, 1'b0, 8'h13);
      check("m1_fields", 64'({bus.out_bank, bus.out_bg, bus.out_col, bus.out_row}),
            64'({2'd1, 2'd1, 10'd0, 16'd0}));
      drain_one();

      single("m2", 40'h28, 2'd2, 1'b0, 8'h14);
      check("m2_fields", 64'({bus.out_col, bus.out_bg, bus.out_bank}),
            64'({10'd5, 2'd0, 2'd0}));
      drain_one();

      single("oor", 40'h4_0000_0000, 2'd0, 1'b0, 8'h15);
      check("oor_vec", 64'(obs_vec()), 64'({31'd0, 8'h15, 1'b1}));
      drain_one();

      single("m3", 40'hB2038, 2'd3, 1'b0, 8'h16);
      check("m3_vec", 64'(obs_vec()), 64'({1'b0, 2'd2, 2'd1, 16'd5, 10'd7, 8'h16, 1'b1}));
      drain_one();

      // Back-to-back IDs 1..4 against a stalled consumer.
      @(negedge clk);
      cfg_mode = 2'd0;
      cfg_xor_en = 1'b0;
      bus.in_addr = 40'h1000;
      bus.in_id = 8'd1;
      bus.in_valid = 1'b1;
      bus.out_ready = 1'b0;
      @(negedge clk);
      bus.in_id = 8'd2;
      #1 check("stall_rdy_2nd", 64'(bus.in_ready), 64'd1);
      @(negedge clk);
      bus.in_id = 8'd3;
      #1 check("stall_rdy_low", 64'(bus.in_ready), 64'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stall_hold_vec", 64'(obs_vec()), 64'(model(40'h1000, 2'd0, 1'b0, 8'd1)));
         check("stall_hold_rdy", 64'({bus.out_valid, bus.in_ready}), 64'd2);
      end
      bus.out_ready = 1'b1;
      exp_out = 1;
      for (int c = 0; c < 6; c++) begin
         #1;
         acc = bus.in_valid && bus.in_ready;
         if (exp_out <= 4) begin
            check("order_valid", 64'(bus.out_valid), 64'd1);
            check("order_id", 64'(bus.out_id), 64'(exp_out));
            exp_out++;
         end
         @(negedge clk);
         if (acc) begin
            if (bus.in_id == 8'd4) bus.in_valid = 1'b0;
            else bus.in_id = bus.in_id + 8'd1;
         end
      end
      check("order_empty", 64'(bus.out_valid), 64'd0);

`ifdef OPENDDR_ADDR_STATS_EN
      stat_clr = 1'b1;
      @(negedge clk);
      stat_clr = 1'b0;
`endif

      // Randomized stream with random back-pressure and per-cycle config changes.
      hs = 0;
      errs = 0;
      pend = 1'b0;
      for (int c = 0; c < 500; c++) begin
         @(negedge clk);
         if (!pend) begin
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.in_addr = rand_addr();
            bus.in_id = 8'($urandom);
         end
         cfg_mode = 2'($urandom_range(0, 3));
         cfg_xor_en = 1'($urandom_range(0, 1));
         bus.out_ready = ($urandom_range(0, 2) != 0);
         #1;
         if (bus.in_valid && bus.in_ready) begin
            q.push_back(model(bus.in_addr, cfg_mode, cfg_xor_en, bus.in_id));
            pend = 1'b0;
         end else begin
            pend = bus.in_valid;
         end
         if (bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
               check("rand_spurious", 64'd1, 64'd0);
            end else begin
               exp_v = q.pop_front();
               check("rand_vec", 64'(obs_vec()), 64'(exp_v));
               hs++;
               if (exp_v[0]) errs++;
            end
         end
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      for (int c = 0; c < 10 && q.size() > 0; c++) begin
         #1;
         if (bus.out_valid) begin
            exp_v = q.pop_front();
            check("drain_vec", 64'(obs_vec()), 64'(exp_v));
            hs++;
            if (exp_v[0]) errs++;
         end
         @(negedge clk);
      end
      check("drain_left", 64'(q.size()), 64'd0);
`ifdef OPENDDR_ADDR_STATS_EN
      check("stat_req", 64'(stat_req_cnt), 64'(hs));
      check("stat_err", 64'(stat_err_cnt), 64'(errs));
`endif

      // Reset with two transactions in flight.
      @(negedge clk);
      bus.out_ready = 1'b0;
      cfg_mode = 2'd0;
      cfg_xor_en = 1'b0;
      bus.in_addr = 40'hB2038;
      bus.in_id = 8'hA1;
      bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_id = 8'hA2;
      @(negedge clk);
      bus.in_valid = 1'b0;
      check("rst_pre_valid", 64'({bus.out_valid, bus.out_id}), 64'({1'b1, 8'hA1}));
      #2 rst_n = 1'b0;
      #1;
      check("rst_async_valid", 64'(bus.out_valid), 64'd0);
      check("rst_async_vec", 64'(obs_vec()), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_no_stale", 64'({bus.out_valid, bus.in_ready}), 64'd1);
      end
`ifdef OPENDDR_ADDR_STATS_EN
      check("rst_stats", 64'({stat_req_cnt, stat_err_cnt}), 64'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
